aes_kb_search: RTL and testbench

- Parametrised successor to the single-candidate AES key-block checker.
- Accepts one encrypted MD5 hash plus NUM_CAND candidate 448-bit key blocks.
- For each candidate in turn: pads the block, streams it into the external md5 core, uses the digest as the AES key, runs the external aes core, and compares the decrypted result with the digest.
- Stops at the first match and reports the key and candidate index. Adds a hash-done watchdog, a stall freeze and an error flag, none of which the previous generation had.

---
 rtl/aes_kb_search.sv | 226 ++++++++++++++++++++++
 tb/tb_aes_kb_search.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_kb_search.sv
// Multi-candidate AES key-block search: each 448-bit candidate is padded and hashed,
// its digest used as an AES key, and the first candidate whose decryption equals its digest wins.
module aes_kb_search #(
    parameter int NUM_CAND     = 4,
    parameter int KB_W         = 448,
    parameter int KEY_W        = 128,
    parameter int AES_LAT      = 38,
    parameter int HASH_TIMEOUT = 1024,
    parameter int IDX_W        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     start,
    input  logic [KEY_W-1:0]         in_buf,
    input  logic [NUM_CAND*KB_W-1:0] kb_bus,
    output logic                     hash_start,
    output logic                     hash_we,
    output logic [3:0]               hash_wa,
    output logic [31:0]              hash_wd,
    input  logic                     hash_done,
    input  logic [KEY_W-1:0]         hash_digest,
    output logic [KEY_W-1:0]         aes_data_in,
    output logic [KEY_W-1:0]         aes_key,
    input  logic [KEY_W-1:0]         aes_data_out,
    output logic [KEY_W-1:0]         key,
    output logic [IDX_W-1:0]         match_idx,
    output logic                     valid,
    output logic                     done,
    output logic                     err
);

    localparam int CNT_MAX = (HASH_TIMEOUT > AES_LAT) ? HASH_TIMEOUT : AES_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int KB_WORDS = KB_W / 32;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(HASH_TIMEOUT);
    localparam logic [CNT_W-1:0] AES_END     = CNT_W'(AES_LAT - 1);
    localparam logic [IDX_W-1:0] LAST_CAND   = IDX_W'(NUM_CAND - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HWAIT,
        S_CIPHER,
        S_CHECK,
        S_FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          cand_q, cand_d;
    logic [4:0]                wcnt_q, wcnt_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [KEY_W-1:0]          ct_q, ct_d;
    logic [NUM_CAND*KB_W-1:0]  kb_q, kb_d;
    logic [KEY_W-1:0]          dig_q, dig_d;
    logic [KEY_W-1:0]          key_q, key_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;

    logic                      start_c, we_c, done_c;
    logic [3:0]                wa_c;
    logic [4:0]                wcnt_m1;
    logic [31:0]               wd_c;
    logic [KB_W-1:0]           cur_kb;

    // Current candidate block, selected with constant slices only.
    always_comb begin
        cur_kb = kb_q[KB_W-1:0];
        for (int i = 0; i < NUM_CAND; i++) begin
            if (cand_q == IDX_W'(i)) begin
                cur_kb = kb_q[i*KB_W +: KB_W];
            end
        end
    end

    // Write address lags the LOAD counter by one: counter value 0 is the hash_start cycle.
    assign wcnt_m1 = wcnt_q - 5'd1;
    assign wa_c    = wcnt_m1[3:0];

    always_comb begin
        wd_c = 32'h0000_0000;
        if (wa_c == 4'd15) begin
            wd_c = 32'h8000_0000;
        end else begin
            for (int w = 0; w < KB_WORDS; w++) begin
                if (wa_c == 4'(w)) begin
                    wd_c = cur_kb[w*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        wcnt_d  = wcnt_q;
        cnt_d   = cnt_q;
        ct_d    = ct_q;
        kb_d    = kb_q;
        dig_d   = dig_q;
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        err_d   = err_q;
        start_c = 1'b0;
        we_c    = 1'b0;
        done_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ct_d    = in_buf;
                    kb_d    = kb_bus;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    key_d   = '0;
                    idx_d   = '0;
                    cand_d  = '0;
                    wcnt_d  = 5'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (wcnt_q == 5'd0) begin
                    start_c = 1'b1;
                end else begin
                    we_c = 1'b1;
                end
                if (wcnt_q == 5'd16) begin
                    wcnt_d  = 5'd0;
                    cnt_d   = '0;
                    state_d = S_HWAIT;
                end else begin
                    wcnt_d = wcnt_q + 5'd1;
                end
            end
            S_HWAIT: begin
                if (hash_done) begin
                    dig_d   = hash_digest;
                    cnt_d   = '0;
                    state_d = S_CIPHER;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CIPHER: begin
                if (cnt_q == AES_END) begin
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (aes_data_out == dig_q) begin
                    key_d   = dig_q;
                    idx_d   = cand_q;
                    valid_d = 1'b1;
                    state_d = S_FIN;
                end else if (cand_q == LAST_CAND) begin
                    valid_d = 1'b0;
                    state_d = S_FIN;
                end else begin
                    cand_d  = cand_q + 1'b1;
                    wcnt_d  = 5'd0;
                    state_d = S_LOAD;
                end
            end
            S_FIN: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall freezes every register; the strobes are masked so nothing repeats downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            wcnt_q  <= 5'd0;
            cnt_q   <= '0;
            ct_q    <= '0;
            kb_q    <= '0;
            dig_q   <= '0;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (!stall) begin
            state_q <= state_d;
            cand_q  <= cand_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            ct_q    <= ct_d;
            kb_q    <= kb_d;
            dig_q   <= dig_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign hash_start  = start_c & ~stall;
    assign hash_we     = we_c & ~stall;
    assign hash_wa     = hash_we ? wa_c : 4'd0;
    assign hash_wd     = hash_we ? wd_c : 32'h0000_0000;
    assign done        = done_c & ~stall;
    assign aes_key     = dig_q;
    assign aes_data_in = ct_q;
    assign key         = key_q;
    assign match_idx   = idx_q;
    assign valid       = valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_aes_kb_search.sv
// Directed bench for aes_kb_search with small md5/aes behavioural models and
// hand-derived latencies (LOAD 17 + HWAIT delay+1 + CIPHER 38 + CHECK 1 per candidate).
module tb_aes_kb_search;

    localparam int NUM_CAND = 4;
    localparam int KB_W     = 448;
    localparam int KEY_W    = 128;
    localparam int IDX_W    = 4;

    logic                     clk;
    logic                     rst;
    logic                     stall;
    logic                     start;
    logic [KEY_W-1:0]         in_buf;
    logic [NUM_CAND*KB_W-1:0] kb_bus;
    logic                     hash_start;
    logic                     hash_we;
    logic [3:0]               hash_wa;
    logic [31:0]              hash_wd;
    logic                     hash_done;
    logic [KEY_W-1:0]         hash_digest;
    logic [KEY_W-1:0]         aes_data_in;
    logic [KEY_W-1:0]         aes_key;
    logic [KEY_W-1:0]         aes_data_out;
    logic [KEY_W-1:0]         key;
    logic [IDX_W-1:0]         match_idx;
    logic                     valid;
    logic                     done;
    logic                     err;

    aes_kb_search dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .start        (start),
        .in_buf       (in_buf),
        .kb_bus       (kb_bus),
        .hash_start   (hash_start),
        .hash_we      (hash_we),
        .hash_wa      (hash_wa),
        .hash_wd      (hash_wd),
        .hash_done    (hash_done),
        .hash_digest  (hash_digest),
        .aes_data_in  (aes_data_in),
        .aes_key      (aes_key),
        .aes_data_out (aes_data_out),
        .key          (key),
        .match_idx    (match_idx),
        .valid        (valid),
        .done         (done),
        .err          (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [KEY_W-1:0] got, input logic [KEY_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [31:0]      kb_words [NUM_CAND][14];
    logic [KEY_W-1:0] cand_dig [NUM_CAND];
    logic [3:0]       match_mask = 4'b0000;
    int               hash_delay = 1;
    bit               hash_off   = 1'b0;
    int               hs_base    = 0;

    function automatic logic [KEY_W-1:0] dig_of(input logic [31:0] w0, input logic [31:0] w1,
                                                input logic [31:0] w2, input logic [31:0] w3,
                                                input logic [31:0] w13);
        return {w0 ^ w13, w1, w2 + 32'h1234_5678, ~w3};
    endfunction

    function automatic logic [31:0] exp_word(input int c, input logic [3:0] a);
        if (a == 4'd14) return 32'h0000_0000;
        if (a == 4'd15) return 32'h8000_0000;
        if (c < 0 || c >= NUM_CAND) return 32'hDEAD_BEEF;
        return kb_words[c][a];
    endfunction

    // monitors
    int cyc      = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (hash_start) hs_cnt <= hs_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    // md5 model: checks every write, raises hash_done hash_delay edges after word 15
    logic [31:0] mw [16];
    int          dcnt   = 0;
    int          wa_seq = 0;
    int          cidx;
    initial begin
        hash_done   = 1'b0;
        hash_digest = '0;
    end
    always @(posedge clk) begin
        hash_done <= 1'b0;
        if (!rst) begin
            dcnt = 0;
        end else begin
            if (dcnt > 0) begin
                if (dcnt == 1) begin
                    hash_done   <= 1'b1;
                    hash_digest <= dig_of(mw[0], mw[1], mw[2], mw[3], mw[13]);
                end
                dcnt--;
            end
            if (hash_start) wa_seq = 0;
            if (hash_we) begin
                cidx = hs_cnt - hs_base - 1;
                check("hash_wa", KEY_W'(hash_wa), KEY_W'(wa_seq));
                check("hash_wd", KEY_W'(hash_wd), KEY_W'(exp_word(cidx, 4'(wa_seq))));
                mw[hash_wa] = hash_wd;
                wa_seq++;
                if (hash_wa == 4'd15 && !hash_off) dcnt = hash_delay;
            end
        end
    end

    // aes model: decryption equals the key only for digests of candidates in match_mask
    always_comb begin
        aes_data_out = ~aes_key;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (match_mask[i] && aes_key == cand_dig[i]) aes_data_out = aes_key;
        end
    end

    task automatic check_idle_zero(input string tag);
        check({tag, "_key"}, key, '0);
        check({tag, "_valid"}, KEY_W'(valid), '0);
        check({tag, "_idx"}, KEY_W'(match_idx), '0);
        check({tag, "_err"}, KEY_W'(err), '0);
        check({tag, "_done"}, KEY_W'(done), '0);
        check({tag, "_hstart"}, KEY_W'(hash_start), '0);
        check({tag, "_hwe"}, KEY_W'(hash_we), '0);
        check({tag, "_aeskey"}, aes_key, '0);
        check({tag, "_aesin"}, aes_data_in, '0);
    endtask

    task automatic run_req(input string name, input logic [3:0] mask, input int delay,
                           input bit no_hash, input bit do_stall, input logic [KEY_W-1:0] ct,
                           input bit exp_valid, input int exp_idx, input bit exp_err,
                           input int exp_tried, input int exp_lat);
        int  t0;
        int  dc0;
        int  n;
        bit  seen;
        match_mask = mask;
        hash_delay = delay;
        hash_off   = no_hash;
        @(negedge clk);
        hs_base = hs_cnt;
        in_buf  = ct;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        dc0   = done_cnt;
        seen  = 1'b0;
        n     = 0;
        while (!seen && n < 3000) begin
            stall = do_stall && ((n >= 5 && n < 10) || (n >= 40 && n < 45));
            @(negedge clk);
            n = cyc - t0;
            if (done) seen = 1'b1;
        end
        stall = 1'b0;
        check({name, "_done_seen"}, KEY_W'(seen), 1);
        check({name, "_latency"}, KEY_W'(cyc - t0), KEY_W'(exp_lat));
        @(negedge clk);
        check({name, "_done_pulses"}, KEY_W'(done_cnt - dc0), 1);
        check({name, "_valid"}, KEY_W'(valid), KEY_W'(exp_valid));
        check({name, "_err"}, KEY_W'(err), KEY_W'(exp_err));
        check({name, "_idx"}, KEY_W'(match_idx), exp_valid ? KEY_W'(exp_idx) : '0);
        check({name, "_key"}, key, exp_valid ? cand_dig[exp_idx] : '0);
        check({name, "_hash_starts"}, KEY_W'(hs_cnt - hs_base), KEY_W'(exp_tried));
        check({name, "_aes_in"}, aes_data_in, ct);
    endtask

    initial begin
        int t0;
        int dc0;
        rst    = 1'b0;
        stall  = 1'b0;
        start  = 1'b0;
        in_buf = '0;
        kb_bus = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            for (int w = 0; w < 14; w++) begin
                kb_words[i][w] = 32'((i + 1) * 32'h1111_0000 + w * 32'h0000_0101 + 32'h0A0B);
            end
            cand_dig[i] = dig_of(kb_words[i][0], kb_words[i][1], kb_words[i][2],
                                 kb_words[i][3], kb_words[i][13]);
        end
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            for (int w = 13; w >= 0; w--) begin
                kb_bus = {kb_bus[NUM_CAND*KB_W-33:0], kb_words[i][w]};
            end
        end

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // per-candidate latency = 57 + delay
        run_req("cand0", 4'b0001, 1, 1'b0, 1'b0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                1'b1, 0, 1'b0, 1, 58);
        run_req("first_wins", 4'b1100, 2, 1'b0, 1'b0, 128'hFEDC_BA98_7654_3210_FFEE_DDCC_BBAA_9988,
                1'b1, 2, 1'b0, 3, 177);
        run_req("no_match", 4'b0000, 4, 1'b0, 1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
                1'b0, 0, 1'b0, 4, 244);
        run_req("timeout", 4'b1111, 1, 1'b1, 1'b0, 128'hA5A5_A5A5_5A5A_5A5A_C3C3_C3C3_3C3C_3C3C,
                1'b0, 0, 1'b1, 1, 1042);
        run_req("stall", 4'b0001, 3, 1'b0, 1'b1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                1'b1, 0, 1'b0, 1, 70);

        // reset in the middle of CIPHER aborts without a done pulse
        match_mask = 4'b1000;
        hash_delay = 2;
        hash_off   = 1'b0;
        @(negedge clk);
        hs_base = hs_cnt;
        in_buf  = 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        while (cyc - t0 < 30) @(negedge clk);
        check("pre_reset_aes_in", aes_data_in, 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D);
        dc0 = done_cnt;
        rst = 1'b0;
        #1;
        check_idle_zero("mid_reset");
        repeat (5) @(negedge clk);
        check("mid_reset_no_done", KEY_W'(done_cnt - dc0), 0);
        rst = 1'b1;
        run_req("after_reset", 4'b1000, 2, 1'b0, 1'b0, 128'h0F0F_0F0F_F0F0_F0F0_0F0F_0F0F_F0F0_F0F0,
                1'b1, 3, 1'b0, 4, 236);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
